// File: rtl/filter_seq_pkg.sv
// Shared types, default parameters and the radius clamp for filter_frame_sequencer.
package filter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FEED   = 2'd1,
        DRAIN  = 2'd2,
        BYPASS = 2'd3
    } state_t;

    typedef enum logic {
        BYPASS_MODE = 1'b0,
        BLUR_MODE   = 1'b1
    } filter_mode_t;

    localparam int unsigned DEF_IMG_WIDTH      = 640;
    localparam int unsigned DEF_IMG_HEIGHT     = 480;
    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_MAX_RADIUS     = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1048576;

    function automatic logic [7:0] clamp_radius(input logic [7:0] req, input logic [7:0] max_r);
        return (req > max_r) ? max_r : req;
    endfunction

endpackage

// File: rtl/frame_pixel_counter.sv
// Per-frame pixel counter: wraps to zero after the TOTAL-th enable, flags the last position.
module frame_pixel_counter #(
    parameter int unsigned TOTAL = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_last
);

    localparam int unsigned CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    logic [CNT_W-1:0] r_count;

    assign o_last = (r_count == CNT_W'(TOTAL - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= o_last ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/filter_frame_sequencer.sv
// Frame admission, radius latch and output routing around a frame-buffered blur filter.
// Optional drain watchdog enabled by defining FILTER_SEQ_WATCHDOG_EN.
module filter_frame_sequencer
    import filter_seq_pkg::*;
#(
    parameter int unsigned IMG_WIDTH      = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT     = DEF_IMG_HEIGHT,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned MAX_RADIUS     = DEF_MAX_RADIUS,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  pixel_in_valid,
    input  logic                  pixel_in_sof,
    input  logic                  filter_sel,
    input  logic [7:0]            blur_radius_req,
    output logic [DATA_WIDTH-1:0] flt_pixel,
    output logic                  flt_pixel_valid,
    output logic [7:0]            flt_radius,
    input  logic                  flt_busy,
    input  logic [DATA_WIDTH-1:0] flt_pixel_out,
    input  logic                  flt_pixel_out_valid,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  pixel_out_valid,
    output logic                  frame_done,
    output logic                  frame_dropped,
    output logic [15:0]           drop_count,
    output logic                  timeout_err,
    output logic                  busy
);

    localparam int unsigned TOTAL = IMG_WIDTH * IMG_HEIGHT;

    state_t                r_state, w_state_d;
    logic [DATA_WIDTH-1:0] r_flt_pixel, r_pixel_out, w_pixel_out_d;
    logic                  r_flt_valid, r_out_valid, r_frame_done, r_frame_dropped, r_timeout;
    logic                  w_flt_valid_d, w_out_valid_d, w_frame_done_d, w_frame_dropped_d;
    logic                  w_timeout_d;
    logic [7:0]            r_flt_radius, w_radius_d;
    logic [15:0]           r_drop_count;
    logic                  w_in_en, w_in_last, w_out_en, w_out_clr, w_out_last;
    logic                  w_sof, w_wd_expired;
    filter_mode_t          w_mode;

    assign w_sof  = pixel_in_valid && pixel_in_sof;
    assign w_mode = filter_mode_t'(filter_sel);

    frame_pixel_counter #(.TOTAL(TOTAL)) u_in_counter (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (1'b0),
        .i_enable (w_in_en),
        .o_last   (w_in_last)
    );

    frame_pixel_counter #(.TOTAL(TOTAL)) u_out_counter (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_out_clr),
        .i_enable (w_out_en),
        .o_last   (w_out_last)
    );

`ifdef FILTER_SEQ_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd_count;

    assign w_wd_expired = (r_state == DRAIN) && !flt_pixel_out_valid &&
                          (r_wd_count == WD_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside DRAIN so every DRAIN entry starts a fresh window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd_count <= '0;
        end else if ((r_state != DRAIN) || flt_pixel_out_valid || w_wd_expired) begin
            r_wd_count <= '0;
        end else begin
            r_wd_count <= r_wd_count + WD_W'(1);
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_wd_expired     = 1'b0;
`endif

    always_comb begin
        w_state_d         = r_state;
        w_in_en           = 1'b0;
        w_out_en          = 1'b0;
        w_out_clr         = 1'b0;
        w_flt_valid_d     = 1'b0;
        w_out_valid_d     = 1'b0;
        w_pixel_out_d     = pixel_in;
        w_frame_done_d    = 1'b0;
        w_frame_dropped_d = 1'b0;
        w_timeout_d       = 1'b0;
        w_radius_d        = r_flt_radius;
        unique case (r_state)
            IDLE: begin
                if (w_sof) begin
                    if (w_mode == BYPASS_MODE) begin
                        w_out_valid_d  = 1'b1;
                        w_in_en        = 1'b1;
                        w_frame_done_d = w_in_last;
                        w_state_d      = w_in_last ? IDLE : BYPASS;
                    end else if (!flt_busy) begin
                        w_radius_d    = clamp_radius(blur_radius_req, 8'(MAX_RADIUS));
                        w_flt_valid_d = 1'b1;
                        w_in_en       = 1'b1;
                        w_state_d     = w_in_last ? DRAIN : FEED;
                    end else begin
                        w_frame_dropped_d = 1'b1;
                    end
                end
            end
            FEED: begin
                if (pixel_in_valid) begin
                    w_flt_valid_d = 1'b1;
                    w_in_en       = 1'b1;
                    if (w_in_last) w_state_d = DRAIN;
                end
            end
            DRAIN: begin
                w_frame_dropped_d = w_sof;
                w_pixel_out_d     = flt_pixel_out;
                if (flt_pixel_out_valid) begin
                    w_out_valid_d = 1'b1;
                    w_out_en      = 1'b1;
                    if (w_out_last) begin
                        w_frame_done_d = 1'b1;
                        w_state_d      = IDLE;
                    end
                end else if (w_wd_expired) begin
                    w_timeout_d = 1'b1;
                    w_out_clr   = 1'b1;
                    w_state_d   = IDLE;
                end
            end
            BYPASS: begin
                if (pixel_in_valid) begin
                    w_out_valid_d = 1'b1;
                    w_in_en       = 1'b1;
                    if (w_in_last) begin
                        w_frame_done_d = 1'b1;
                        w_state_d      = IDLE;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_flt_pixel     <= '0;
            r_flt_valid     <= 1'b0;
            r_pixel_out     <= '0;
            r_out_valid     <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_dropped <= 1'b0;
            r_timeout       <= 1'b0;
            r_flt_radius    <= '0;
            r_drop_count    <= '0;
        end else begin
            r_state         <= w_state_d;
            r_flt_valid     <= w_flt_valid_d;
            r_out_valid     <= w_out_valid_d;
            r_frame_done    <= w_frame_done_d;
            r_frame_dropped <= w_frame_dropped_d;
            r_timeout       <= w_timeout_d;
            r_flt_radius    <= w_radius_d;
            if (w_flt_valid_d) r_flt_pixel <= pixel_in;
            if (w_out_valid_d) r_pixel_out <= w_pixel_out_d;
            if (w_frame_dropped_d && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign flt_pixel       = r_flt_pixel;
    assign flt_pixel_valid = r_flt_valid;
    assign flt_radius      = r_flt_radius;
    assign pixel_out       = r_pixel_out;
    assign pixel_out_valid = r_out_valid;
    assign frame_done      = r_frame_done;
    assign frame_dropped   = r_frame_dropped;
    assign drop_count      = r_drop_count;
    assign timeout_err     = r_timeout;
    assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Directed scoreboard bench for filter_frame_sequencer with an 4x2 frame (TOTAL = 8).
module tb_filter_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pixel_in;
    logic       pixel_in_valid, pixel_in_sof, filter_sel;
    logic [7:0] blur_radius_req;
    logic [7:0] flt_pixel, flt_radius, flt_pixel_out, pixel_out;
    logic       flt_pixel_valid, flt_busy, flt_pixel_out_valid, pixel_out_valid;
    logic       frame_done, frame_dropped, timeout_err, busy;
    logic [15:0] drop_count;

    typedef struct {logic [7:0] d; logic [7:0] r;} flt_exp_t;
    typedef struct {logic [7:0] d; logic done;} out_exp_t;

    flt_exp_t flt_q[$];
    out_exp_t out_q[$];
    int vectors = 0;
    int miscompares = 0;
    int drop_seen = 0;

    always #5 clk = ~clk;

    filter_frame_sequencer #(
        .IMG_WIDTH      (4),
        .IMG_HEIGHT     (2),
        .DATA_WIDTH     (8),
        .MAX_RADIUS     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .pixel_in            (pixel_in),
        .pixel_in_valid      (pixel_in_valid),
        .pixel_in_sof        (pixel_in_sof),
        .filter_sel          (filter_sel),
        .blur_radius_req     (blur_radius_req),
        .flt_pixel           (flt_pixel),
        .flt_pixel_valid     (flt_pixel_valid),
        .flt_radius          (flt_radius),
        .flt_busy            (flt_busy),
        .flt_pixel_out       (flt_pixel_out),
        .flt_pixel_out_valid (flt_pixel_out_valid),
        .pixel_out           (pixel_out),
        .pixel_out_valid     (pixel_out_valid),
        .frame_done          (frame_done),
        .frame_dropped       (frame_dropped),
        .drop_count          (drop_count),
        .timeout_err         (timeout_err),
        .busy                (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic sof, input logic sel, input logic [7:0] rad,
                        input logic exp_flt, input logic [7:0] exp_rad,
                        input logic exp_out, input logic exp_done);
        pixel_in        = d;
        pixel_in_valid  = 1'b1;
        pixel_in_sof    = sof;
        filter_sel      = sel;
        blur_radius_req = rad;
        if (exp_flt) flt_q.push_back('{d: d, r: exp_rad});
        if (exp_out) out_q.push_back('{d: d, done: exp_done});
        cyc();
        pixel_in_valid = 1'b0;
        pixel_in_sof   = 1'b0;
    endtask

    task automatic send_flt(input logic [7:0] d, input logic exp_out, input logic exp_done);
        flt_pixel_out       = d;
        flt_pixel_out_valid = 1'b1;
        if (exp_out) out_q.push_back('{d: d, done: exp_done});
        cyc();
        flt_pixel_out_valid = 1'b0;
    endtask

    // Scoreboard side: every DUT output beat must match the head of its queue.
    always @(negedge clk) begin
        if (flt_pixel_valid) begin
            if (flt_q.size() == 0) begin
                chk("flt_valid_expected", {31'b0, flt_pixel_valid}, {31'b0, (flt_q.size() != 0)});
            end else begin
                flt_exp_t e;
                e = flt_q.pop_front();
                chk("flt_pixel", flt_pixel, e.d);
                chk("flt_radius", flt_radius, e.r);
            end
        end
        if (pixel_out_valid) begin
            if (out_q.size() == 0) begin
                chk("out_valid_expected", {31'b0, pixel_out_valid}, {31'b0, (out_q.size() != 0)});
            end else begin
                out_exp_t o;
                o = out_q.pop_front();
                chk("pixel_out", pixel_out, o.d);
                chk("frame_done", frame_done, o.done);
            end
        end else if (frame_done) begin
            chk("done_without_valid", frame_done, pixel_out_valid);
        end
        if (frame_dropped) drop_seen++;
    end

    initial begin
        reset               = 1'b0;
        pixel_in            = '0;
        pixel_in_valid      = 1'b0;
        pixel_in_sof        = 1'b0;
        filter_sel          = 1'b0;
        blur_radius_req     = '0;
        flt_busy            = 1'b0;
        flt_pixel_out       = '0;
        flt_pixel_out_valid = 1'b0;
        repeat (3) cyc();
        chk("rst_flt_valid", flt_pixel_valid, 0);
        chk("rst_out_valid", pixel_out_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_dropped", frame_dropped, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_radius", flt_radius, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        cyc();

        // Bypass frame
        for (int i = 0; i < 8; i++) begin
            send(8'h10 + 8'(i), i == 0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, i == 7);
            if (i == 3) chk("bypass_busy", busy, 1);
        end
        cyc(); cyc();
        chk("bypass_idle", busy, 0);
        chk("bypass_out_q", out_q.size(), 0);

        // Blur frame, radius 9 clamps to 4
        for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), i == 0, 1'b1, 8'd9, 1'b1, 8'd4, 1'b0, 1'b0);
        cyc();
        chk("blur_drain_busy", busy, 1);
        chk("blur_flt_q", flt_q.size(), 0);
        for (int i = 0; i < 8; i++) send_flt(8'hA0 + 8'(i), 1'b1, i == 7);
        cyc(); cyc();
        chk("blur_idle", busy, 0);
        chk("blur_out_q", out_q.size(), 0);

        // Filter output outside DRAIN is ignored
        send_flt(8'hEE, 1'b0, 1'b0);
        cyc();
        chk("stray_flt_busy", busy, 0);

        // Refused frame while filter busy
        flt_busy = 1'b1;
        for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), i == 0, 1'b1, 8'd2, 1'b0, 8'd0, 1'b0, 1'b0);
        flt_busy = 1'b0;
        cyc();
        chk("busy_drop_seen", drop_seen, 1);
        chk("busy_drop_count", drop_count, 1);
        chk("busy_radius_held", flt_radius, 4);
        chk("busy_state", busy, 0);

        // Sof during DRAIN is dropped; next frame accepted normally
        for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), i == 0, 1'b1, 8'd2, 1'b1, 8'd2, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send(8'h50 + 8'(i), i == 0, 1'b1, 8'd7, 1'b0, 8'd0, 1'b0, 1'b0);
        cyc();
        chk("drain_drop_seen", drop_seen, 2);
        chk("drain_drop_count", drop_count, 2);
        chk("drain_still_busy", busy, 1);
        chk("drain_radius", flt_radius, 2);
        for (int i = 0; i < 8; i++) send_flt(8'hB0 + 8'(i), 1'b1, i == 7);
        cyc();
        chk("drain_idle", busy, 0);
        for (int i = 0; i < 8; i++) send(8'h70 + 8'(i), i == 0, 1'b1, 8'd3, 1'b1, 8'd3, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_flt(8'hC0 + 8'(i), 1'b1, i == 7);
        cyc(); cyc();
        chk("after_drain_idle", busy, 0);
        chk("after_drain_q", out_q.size() + flt_q.size(), 0);

        // Reset after 3 pixels in FEED
        for (int i = 0; i < 3; i++) send(8'h80 + 8'(i), i == 0, 1'b1, 8'd1, 1'b1, 8'd1, 1'b0, 1'b0);
        cyc();
        chk("feed_busy", busy, 1);
        reset = 1'b0;
        #2;
        chk("mid_rst_flt_valid", flt_pixel_valid, 0);
        chk("mid_rst_flt_pixel", flt_pixel, 0);
        chk("mid_rst_radius", flt_radius, 0);
        chk("mid_rst_drop_count", drop_count, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", frame_done, 0);
        cyc();
        reset = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) send(8'h60 + 8'(i), i == 0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, i == 7);
        cyc(); cyc();
        chk("post_rst_idle", busy, 0);
        chk("post_rst_q", out_q.size() + flt_q.size(), 0);

`ifdef FILTER_SEQ_WATCHDOG_EN
        begin
            int n;
            for (int i = 0; i < 8; i++) send(8'h90 + 8'(i), i == 0, 1'b1, 8'd1, 1'b1, 8'd1, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) send_flt(8'hD0 + 8'(i), 1'b1, 1'b0);
            n = 0;
            while (!timeout_err && n < 40) begin
                cyc();
                n++;
            end
            chk("wd_delay", n, 16);
            cyc();
            chk("wd_busy", busy, 0);
            chk("wd_out_q", out_q.size(), 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
